// File: rtl/irq_ctrl_if.sv
// Avalon-MM style slave bus for irq_ctrl:
// 3-bit address, 16-bit data, active-low write strobe.
interface irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt aggregator: edge/level capture, mask, priority vector.
// Define IRQ_CTRL_SYNC_EN for 2-flop input synchronizers.
module irq_ctrl #(
  parameter int NUM_SRC = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  irq_ctrl_if.slave          bus,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq
);

  typedef logic [NUM_SRC-1:0] src_t;

  src_t in_c;
  src_t in_d;
  src_t capture;
  src_t mask_r;
  src_t edge_r;
  src_t pending;
  src_t active;
  src_t cap_set;
  src_t cap_clr;
  src_t wdata;

  logic        wr;
  logic        wr_pend;
  logic        wr_mask;
  logic        wr_edge;
  logic        wr_swset;
  logic        valid;
  logic [3:0]  index;
  logic [15:0] rmux;

`ifdef IRQ_CTRL_SYNC_EN
  src_t sync1;
  src_t sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end

  assign in_c = sync2;
`else
  assign in_c = irq_in;
`endif

  assign wdata    = bus.writedata[NUM_SRC-1:0];
  assign wr       = bus.chipselect & ~bus.write_n;
  assign wr_pend  = wr && (bus.address == 3'd1);
  assign wr_mask  = wr && (bus.address == 3'd2);
  assign wr_edge  = wr && (bus.address == 3'd3);
  assign wr_swset = wr && (bus.address == 3'd5);

  assign cap_set = (edge_r & in_c & ~in_d)
                 | (wr_swset ? wdata : '0);
  assign cap_clr = wr_pend ? wdata : '0;

  assign pending = capture | (in_c & ~edge_r);
  assign active  = pending & mask_r;
  assign valid   = |active;

  // Scan downward so the lowest active bit wins.
  always_comb begin
    index = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) index = 4'(i);
    end
  end

  always_comb begin
    rmux = 16'h0000;
    unique case (bus.address)
      3'd0:    rmux = 16'(in_c);
      3'd1:    rmux = 16'(pending);
      3'd2:    rmux = 16'(mask_r);
      3'd3:    rmux = 16'(edge_r);
      3'd4:    rmux = {valid, 11'b0, index};
      default: rmux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_d    <= '0;
      capture <= '0;
      mask_r  <= '0;
      edge_r  <= '0;
      irq     <= 1'b0;
    end else begin
      in_d    <= in_c;
      // Set wins over a simultaneous software clear.
      capture <= (capture & ~cap_clr) | cap_set;
      if (wr_mask) mask_r <= wdata;
      if (wr_edge) edge_r <= wdata;
      irq     <= valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= 16'h0000;
    end else if (bus.chipselect) begin
      bus.readdata <= rmux;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic        clk;
  logic        reset_n;
  logic [15:0] irq_in;
  logic        irq;
  logic [15:0] rd;
  int          tests;
  int          fails;

  irq_ctrl_if bus ();

  irq_ctrl #(.NUM_SRC(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .irq_in  (irq_in),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [15:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = a;
    tick();
    bus.chipselect = 1'b0;
    d = bus.readdata;
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    reset_n        = 1'b0;
    irq_in         = 16'h0000;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 16'h0000;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_irq", 16'(irq), 16'h0000);
    check("rst_rd", bus.readdata, 16'h0000);
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), rd);
      check($sformatf("rst_reg%0d", a), rd, 16'h0000);
    end

    // Level source 0
    wr(3'd2, 16'h0001);
    irq_in[0] = 1'b1;
    repeat (SYNC) tick();
    check("lvl_irq_before", 16'(irq), 16'h0000);
    tick();
    check("lvl_irq_rise", 16'(irq), 16'h0001);
    wr(3'd1, 16'h0001);
    rd_reg(3'd1, rd);
    check("lvl_no_clear", rd, 16'h0001);
    check("lvl_irq_held", 16'(irq), 16'h0001);
    irq_in[0] = 1'b0;
    repeat (SYNC) tick();
    check("lvl_irq_still", 16'(irq), 16'h0001);
    tick();
    check("lvl_irq_fall", 16'(irq), 16'h0000);

    // Edge source 2
    wr(3'd3, 16'h0004);
    wr(3'd2, 16'h0004);
    irq_in[2] = 1'b1;
    tick();
    irq_in[2] = 1'b0;
    repeat (SYNC) tick();
    check("edge_irq_1cyc", 16'(irq), 16'h0000);
    tick();
    check("edge_irq_2cyc", 16'(irq), 16'h0001);
    rd_reg(3'd1, rd);
    check("edge_pending", rd, 16'h0004);
    check("edge_irq_persist", 16'(irq), 16'h0001);
    irq_in[2] = 1'b1;
    repeat (SYNC) tick();
    wr(3'd1, 16'h0004);
    irq_in[2] = 1'b0;
    rd_reg(3'd1, rd);
    check("edge_set_wins", rd, 16'h0004);
    wr(3'd1, 16'h0004);
    rd_reg(3'd1, rd);
    check("edge_cleared", rd, 16'h0000);
    check("edge_irq_drop", 16'(irq), 16'h0000);
    wr(3'd3, 16'h0000);

    // Software set and vector
    wr(3'd2, 16'h0020);
    wr(3'd5, 16'h0028);
    rd_reg(3'd1, rd);
    check("sw_pending", rd, 16'h0028);
    rd_reg(3'd4, rd);
    check("sw_vector", rd, 16'h8005);
    check("sw_irq", 16'(irq), 16'h0001);
    rd_reg(3'd5, rd);
    check("swset_reads0", rd, 16'h0000);
    wr(3'd1, 16'h0020);
    rd_reg(3'd4, rd);
    check("sw_vector_clr", rd, 16'h0000);
    check("sw_irq_clr", 16'(irq), 16'h0000);
    wr(3'd1, 16'h0008);
    rd_reg(3'd1, rd);
    check("sw_pending_clr", rd, 16'h0000);

    // Level priority
    wr(3'd2, 16'hFFFF);
    irq_in = 16'h0208;
    repeat (SYNC) tick();
    rd_reg(3'd4, rd);
    check("prio_vec_3", rd, 16'h8003);
    irq_in = 16'h0200;
    repeat (SYNC) tick();
    rd_reg(3'd4, rd);
    check("prio_vec_9", rd, 16'h8009);
    rd_reg(3'd0, rd);
    check("raw_bit9", rd, 16'h0200);
    rd_reg(3'd6, rd);
    check("reserved6", rd, 16'h0000);

    // Read in same cycle as write returns old value
    wr(3'd2, 16'h0001);
    check("rd_pre_write", bus.readdata, 16'hFFFF);
    rd_reg(3'd2, rd);
    check("mask_written", rd, 16'h0001);

    // Asynchronous reset mid-operation
    wr(3'd2, 16'h0200);
    rd_reg(3'd4, rd);
    check("pre_rst_vec", rd, 16'h8009);
    check("pre_rst_irq", 16'(irq), 16'h0001);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_irq", 16'(irq), 16'h0000);
    check("async_rd", bus.readdata, 16'h0000);
    tick();
    reset_n = 1'b1;
    tick();
    rd_reg(3'd2, rd);
    check("post_rst_mask", rd, 16'h0000);
    rd_reg(3'd3, rd);
    check("post_rst_edge", rd, 16'h0000);
    check("post_rst_irq", 16'(irq), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
